seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Self-timed, parametrised multiplexed seven-segment display controller for the board's common-anode digit bank.
- Owns the refresh divider and digit rotation, and decodes a full hex font (0-F).
- Adds per-digit decimal points, per-digit enables, leading-zero suppression and an anti-ghosting blank interval.
- Display data is double-buffered, so a new value never tears mid-frame.
- Sits between application logic (counters, reaction timers) and the dig/smg pins.

Parameters:
- NUM_DIG, 4, number of multiplexed digits (2..8).
- SCAN_DIV, 12000, clk cycles per digit slot (1 ms at 12 MHz); must be > BLANK_CYC.
- BLANK_CYC, 120, cycles at the start of each slot with all digits off (anti-ghost); 0 disables.
- SEG_INV, 0, 1 inverts the entire smg output.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle strobe; captures data_in/dp_in/en_in/lz_sup into the shadow registers
- data_in  in  4*NUM_DIG  hex nibble per digit; nibble k drives digit k; digit 0 is least significant (rightmost)
- dp_in  in  NUM_DIG  decimal point per digit, 1 = lit
- en_in  in  NUM_DIG  digit enable, 0 = digit fully blank
- lz_sup  in  1  leading-zero suppression enable
- dig  out  NUM_DIG  digit select, active-low one-hot
- smg  out  8  segments; bit0=G, 1=F, 2=E, 3=D, 4=C, 5=B, 6=A, 7=P; 1 = lit when SEG_INV=0
- frame_done  out  1  one-cycle pulse at the end of the last digit slot

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state:
  - dig = all 1s; smg = 8'h00 (8'hFF if SEG_INV); frame_done = 0.
  - div counter = 0; slot = 0; pending = 0.
  - Active and shadow registers cleared, so en = 0 and the display is blank until the first load/swap.
- Divider: div counts 0..SCAN_DIV-1 and wraps. On div == SCAN_DIV-1:
  - slot advances, wrapping from NUM_DIG-1 to 0.
  - frame_done = 1 for that cycle when slot == NUM_DIG-1.
- Double buffer and load:
  - load sets pending and overwrites the shadow registers; the latest load before the swap wins.
  - Swap: in the frame_done cycle, if pending, the active registers take the shadow values and pending clears.
  - Simultaneous load and swap in the same cycle: the shadow takes the new data and pending stays set; the new data becomes active at the next frame boundary. The old shadow data is swapped in now.
- Output pipeline: dig/smg are registered and reflect (slot, div) with 1-cycle latency.
- Blanking: while div < BLANK_CYC, dig = all 1s and smg = off.
- Normal slot output:
  - dig = ~(1 << slot).
  - smg = font(active nibble[slot]) | (dp[slot] << 7).
  - If en[slot] = 0, smg = off and dig = all 1s.
- Leading-zero suppression, when the active lz_sup = 1:
  - A digit k > 0 is suppressed if its nibble and every nibble above it are 0.
  - Digit 0 is never suppressed.
  - A suppressed digit shows only its dp; if dp is 0, dig is deasserted.
- Font (SEG_INV=0):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
  - All values hex.
- SEG_INV is applied last, to the final registered smg value.
- Reset mid-frame: immediate blank; pending is discarded.

Decomposition:
- Package seg_pkg holds:
  - Segment bit index constants (SEG_G..SEG_P).
  - The 16-entry font constant array.
  - SEG_OFF.
- One combinational sub-module, seg_hex_font: 4-bit in, 7-bit out, built from the package font.
- Divider, slot FSM, buffering and suppression stay in seg_scan_ctrl.

Test Plan:
- Simulation parameters for all scenarios: NUM_DIG=4, SCAN_DIV=8, BLANK_CYC=2.
- Scenario 1: reset, then load data=16'h1234, en=4'hF, dp=0, lz=0.
  - After the swap, slot0: dig=4'b1110, smg=8'h33; slot3: dig=0111, smg=8'h30.
  - dig = 1111 for the first 2 cycles of every slot.
- Scenario 2: load 16'h00A0, lz=1, dp=4'b0100.
  - Digit3: dig deasserted.
  - Digit2: dig=1011, smg=8'h80 (dp only).
  - Digit1: smg=8'h77.
  - Digit0: smg=8'h7E.
- Scenario 3: load 16'h0000 with lz=1.
  - Only digit0 is lit, smg=8'h7E.
  - Digits 1-3 are never selected.
- Scenario 4: first load 16'h1111, then load 16'h2222 mid-frame.
  - Display shows 1111 until frame_done; from the next frame, 2222 with no mixed digits.
  - A load asserted in the frame_done cycle appears one frame later.
- Scenario 5: SEG_INV=1, data 8 with dp=1 → smg=8'h00.
  - en_in=4'b0101 → digits 1 and 3 are never selected.
- Scenario 6: assert rst_n low mid-slot → dig=1111 and smg=off within the same cycle (asynchronous).
  - frame_done first pulses 32 cycles after release.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared constants for the multiplexed seven-segment scanner.
//   SEG_G..SEG_P : bit positions inside the 8-bit smg bus
//   SEG_OFF      : all segments dark (before any output inversion)
//   SEG_FONT     : 16-entry hex font, bit6=A .. bit0=G, 1 = lit
package seg_pkg;

    localparam int SEG_G = 0;
    localparam int SEG_F = 1;
    localparam int SEG_E = 2;
    localparam int SEG_D = 3;
    localparam int SEG_C = 4;
    localparam int SEG_B = 5;
    localparam int SEG_A = 6;
    localparam int SEG_P = 7;

    localparam logic [7:0] SEG_OFF = 8'h00;

    localparam logic [6:0] SEG_FONT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: application-side load bus plus display pins.
//   load/data_in/dp_in/en_in/lz_sup : driven by the application (master)
//   dig/smg/frame_done              : driven by the scanner (slave)
interface seg_scan_ctrl_if #(
    parameter int NUM_DIG = 4
);
    logic                   load;
    logic [4*NUM_DIG-1:0]   data_in;
    logic [NUM_DIG-1:0]     dp_in;
    logic [NUM_DIG-1:0]     en_in;
    logic                   lz_sup;
    logic [NUM_DIG-1:0]     dig;
    logic [7:0]             smg;
    logic                   frame_done;

    modport master (
        output load, data_in, dp_in, en_in, lz_sup,
        input  dig, smg, frame_done
    );

    modport slave (
        input  load, data_in, dp_in, en_in, lz_sup,
        output dig, smg, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl_hex_font.sv
// seg_hex_font: combinational hex-to-seven-segment decoder.
//   hex : nibble 0..F
//   seg : segments A..G (bit6..bit0), 1 = lit
module seg_hex_font
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = SEG_FONT[hex];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed common-anode seven-segment scanner.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : load/data_in/dp_in/en_in/lz_sup in; dig (active-low
//                one-hot), smg (segments + dp), frame_done out
// Each digit owns a SCAN_DIV-cycle slot whose first BLANK_CYC cycles are
// dark. New data lands in a shadow copy and only moves to the active copy
// on the frame boundary, so a frame never shows a mix of old and new.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIG   = 4,
    parameter int SCAN_DIV  = 12000,
    parameter int BLANK_CYC = 120,
    parameter int SEG_INV   = 0
)(
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_ctrl_if.slave  bus
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(NUM_DIG);
    localparam logic [7:0] SMG_IDLE = (SEG_INV != 0) ? ~SEG_OFF : SEG_OFF;

    logic [DW-1:0]            div;
    logic [SW-1:0]            slot;
    logic                     wrap, last_slot, swap;
    logic                     pending;

    logic [NUM_DIG-1:0][3:0]  sh_data, act_data;
    logic [NUM_DIG-1:0]       sh_dp, sh_en, act_dp, act_en;
    logic                     sh_lz, act_lz;

    logic [NUM_DIG-1:0]       hi_zero;
    logic                     suppress, in_blank;
    logic [6:0]               font_seg;
    logic [NUM_DIG-1:0]       dig_nxt;
    logic [7:0]               smg_nxt;

    assign wrap      = (div == DW'(SCAN_DIV - 1));
    assign last_slot = (slot == SW'(NUM_DIG - 1));
    assign swap      = wrap && last_slot && pending;

    // refresh divider and digit rotation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div  <= '0;
            slot <= '0;
        end else begin
            div <= wrap ? '0 : div + DW'(1);
            if (wrap)
                slot <= last_slot ? '0 : slot + SW'(1);
        end
    end

    // Double buffer. The swap reads the shadow before this cycle's load
    // overwrites it, so a load coinciding with the swap stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_en    <= '0;
            sh_lz    <= 1'b0;
            act_data <= '0;
            act_dp   <= '0;
            act_en   <= '0;
            act_lz   <= 1'b0;
        end else begin
            if (swap) begin
                act_data <= sh_data;
                act_dp   <= sh_dp;
                act_en   <= sh_en;
                act_lz   <= sh_lz;
            end
            if (bus.load) begin
                sh_data <= bus.data_in;
                sh_dp   <= bus.dp_in;
                sh_en   <= bus.en_in;
                sh_lz   <= bus.lz_sup;
                pending <= 1'b1;
            end else if (swap) begin
                pending <= 1'b0;
            end
        end
    end

    // hi_zero[k]: nibble k and every nibble above it are zero
    always_comb begin
        hi_zero = '0;
        hi_zero[NUM_DIG-1] = (act_data[NUM_DIG-1] == 4'h0);
        for (int k = NUM_DIG - 2; k >= 0; k--)
            hi_zero[k] = hi_zero[k+1] && (act_data[k] == 4'h0);
    end

    assign suppress = act_lz && (slot != '0) && hi_zero[slot];
    assign in_blank = (int'(div) < BLANK_CYC);

    seg_hex_font u_font (
        .hex (act_data[slot]),
        .seg (font_seg)
    );

    always_comb begin
        dig_nxt = '1;
        smg_nxt = SEG_OFF;
        if (!in_blank && act_en[slot]) begin
            if (!suppress) begin
                dig_nxt              = ~(NUM_DIG'(1) << slot);
                smg_nxt[SEG_A:SEG_G] = font_seg;
                smg_nxt[SEG_P]       = act_dp[slot];
            end else if (act_dp[slot]) begin
                // suppressed zero keeps only its decimal point
                dig_nxt        = ~(NUM_DIG'(1) << slot);
                smg_nxt[SEG_P] = 1'b1;
            end
        end
    end

    // registered pins: one cycle behind (slot, div); frame_done lines up
    // with the last displayed cycle of the last slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dig        <= '1;
            bus.smg        <= SMG_IDLE;
            bus.frame_done <= 1'b0;
        end else begin
            bus.dig        <= dig_nxt;
            bus.smg        <= (SEG_INV != 0) ? ~smg_nxt : smg_nxt;
            bus.frame_done <= wrap && last_slot;
        end
    end

endmodule
